// File: rtl/key_logic_pkg.sv
// Shared types and defaults for the key debounce / LED logic block.
package key_logic_pkg;

  // LED function select decoded from the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_AND    = 2'd1,
    MODE_OR     = 2'd2,
    MODE_TOGGLE = 2'd3
  } key_mode_t;

  localparam int DEFAULT_N_KEYS          = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage : key_logic_pkg

// File: rtl/key_debounce_channel.sv
// One push-button channel: 2-flop synchronizer, stability counter,
// debounced level, press strobe and press-toggle bit.
module key_debounce_channel
  import key_logic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic key_clean,
  output logic press_pulse,
  output logic toggle
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;
  logic          clean_r;
  logic          pulse_r;
  logic          toggle_r;

  // Synchronize the raw key, then accept a new level only after it has
  // differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      cnt_r    <= '0;
      clean_r  <= 1'b0;
      pulse_r  <= 1'b0;
      toggle_r <= 1'b0;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
      if (sync2_r == clean_r) begin
        // Level agrees with the accepted value: any pending count is a bounce.
        cnt_r   <= '0;
        pulse_r <= 1'b0;
      end else if (cnt_r == CNT_LAST) begin
        // Stable long enough: accept; only a 0->1 acceptance is a press.
        clean_r  <= sync2_r;
        cnt_r    <= '0;
        pulse_r  <= sync2_r;
        toggle_r <= toggle_r ^ sync2_r;
      end else begin
        cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        pulse_r <= 1'b0;
      end
    end
  end

  assign key_clean   = clean_r;
  assign press_pulse = pulse_r;
  assign toggle      = toggle_r;

endmodule : key_debounce_channel

// File: rtl/key_logic_debounce.sv
// Top: N_KEYS debounced push-button channels plus a registered LED
// function (pass, pairwise AND, pairwise OR, press-toggle).
module key_logic_debounce
  import key_logic_pkg::*;
#(
  parameter int N_KEYS          = DEFAULT_N_KEYS,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key,
  input  logic [1:0]        mode,
  output logic [N_KEYS-1:0] led,
  output logic [N_KEYS-1:0] key_clean,
  output logic [N_KEYS-1:0] press_pulse
);

  logic [N_KEYS-1:0] clean_s;
  logic [N_KEYS-1:0] pulse_s;
  logic [N_KEYS-1:0] toggle_s;
  logic [N_KEYS-1:0] led_next_s;
  logic [N_KEYS-1:0] led_r;
  key_mode_t         mode_s;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .key        (key[g]),
      .key_clean  (clean_s[g]),
      .press_pulse(pulse_s[g]),
      .toggle     (toggle_s[g])
    );
  end

  assign mode_s = key_mode_t'(mode);

  // Decode the selected LED function from the debounced levels and toggles.
  always_comb begin
    led_next_s = '0;
    case (mode_s)
      MODE_PASS: begin
        led_next_s = clean_s;
      end
      MODE_AND: begin
        for (int j = 0; j < N_KEYS / 2; j++) begin
          led_next_s[2*j] = clean_s[2*j] & clean_s[2*j+1];
        end
      end
      MODE_OR: begin
        for (int j = 0; j < N_KEYS / 2; j++) begin
          led_next_s[2*j] = clean_s[2*j] | clean_s[2*j+1];
        end
      end
      MODE_TOGGLE: begin
        led_next_s = toggle_s;
      end
      default: begin
        led_next_s = '0;
      end
    endcase
  end

  // LED drive register: mode changes show up on the next clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_r <= '0;
    end else begin
      led_r <= led_next_s;
    end
  end

  assign led         = led_r;
  assign key_clean   = clean_s;
  assign press_pulse = pulse_s;

endmodule : key_logic_debounce

// File: tb/tb_key_logic_debounce.sv
// Directed self-checking bench for key_logic_debounce (N_KEYS=8, DEBOUNCE_CYCLES=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too,
// so "after k steps" means k rising edges have seen the new input.
module tb_key_logic_debounce;

  logic       clock;
  logic       reset;
  logic [7:0] key;
  logic [1:0] mode;
  logic [7:0] led;
  logic [7:0] key_clean;
  logic [7:0] press_pulse;

  int vec_count = 0;
  int err_count = 0;

  key_logic_debounce #(
    .N_KEYS         (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key        (key),
    .mode       (mode),
    .led        (led),
    .key_clean  (key_clean),
    .press_pulse(press_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key   = 8'h00;
    mode  = 2'd0;
    step(3);
    vec_count++;
    if ({led, key_clean, press_pulse} !== 24'h000000) begin
      err_count++;
      $display("FAIL reset_state: got led=%b clean=%b pulse=%b want all 0", led, key_clean, press_pulse);
    end
    reset = 1'b0;
    step(2);
  endtask

  // Stable press on key 0: clean at step 6, pulse only at step 6, led at step 7.
  task automatic test_pass();
    mode = 2'd0;
    key  = 8'h01;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      vec_count++;
      if (key_clean[0] !== (k >= 6) || press_pulse[0] !== (k == 6) || led[0] !== (k >= 7)) begin
        err_count++;
        $display("FAIL pass_press step %0d: got clean=%b pulse=%b led=%b want %b %b %b",
                 k, key_clean[0], press_pulse[0], led[0], k >= 6, k == 6, k >= 7);
      end
    end
    key = 8'h00;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      vec_count++;
      if (key_clean[0] !== (k < 6) || press_pulse[0] !== 1'b0) begin
        err_count++;
        $display("FAIL pass_release step %0d: got clean=%b pulse=%b want %b 0",
                 k, key_clean[0], press_pulse[0], k < 6);
      end
    end
  endtask

  // 3 high, 1 low, 3 high: never stable for 4 synchronized cycles.
  task automatic test_bounce();
    logic [6:0] pattern;
    pattern = 7'b1110111;
    for (int k = 0; k < 16; k++) begin
      key[1] = (k < 7) ? pattern[6-k] : 1'b0;
      step(1);
      vec_count++;
      if (key_clean[1] !== 1'b0 || press_pulse[1] !== 1'b0) begin
        err_count++;
        $display("FAIL bounce step %0d: got clean=%b pulse=%b want 0 0", k, key_clean[1], press_pulse[1]);
      end
    end
  endtask

  task automatic test_and();
    mode = 2'd1;
    key  = 8'h0C;
    step(10);
    vec_count++;
    if (led !== 8'b0000_0100) begin
      err_count++;
      $display("FAIL and_both: got led=%b want 00000100", led);
    end
    key = 8'h04;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      vec_count++;
      if (led[2] !== (k < 7)) begin
        err_count++;
        $display("FAIL and_release step %0d: got led[2]=%b want %b", k, led[2], k < 7);
      end
    end
    key = 8'h00;
    step(10);
  endtask

  task automatic test_or();
    mode = 2'd2;
    key  = 8'h40;
    step(10);
    vec_count++;
    if (led !== 8'b0100_0000) begin
      err_count++;
      $display("FAIL or_key6: got led=%b want 01000000", led);
    end
    key = 8'hC0;
    step(10);
    vec_count++;
    if (led !== 8'b0100_0000) begin
      err_count++;
      $display("FAIL or_key67: got led=%b want 01000000", led);
    end
    key = 8'h00;
    step(10);
    vec_count++;
    if (led !== 8'h00) begin
      err_count++;
      $display("FAIL or_released: got led=%b want 00000000", led);
    end
  endtask

  task automatic test_toggle();
    logic [2:0] want;
    want = 3'b101;
    mode = 2'd3;
    for (int p = 0; p < 3; p++) begin
      key[4] = 1'b1;
      step(10);
      vec_count++;
      if (led[4] !== want[2-p]) begin
        err_count++;
        $display("FAIL toggle_press %0d: got led[4]=%b want %b", p, led[4], want[2-p]);
      end
      key[4] = 1'b0;
      step(10);
      vec_count++;
      if (led[4] !== want[2-p]) begin
        err_count++;
        $display("FAIL toggle_release %0d: got led[4]=%b want %b", p, led[4], want[2-p]);
      end
    end
    mode = 2'd0;
    step(1);
    vec_count++;
    if (led !== 8'h00) begin
      err_count++;
      $display("FAIL toggle_to_pass: got led=%b want 00000000", led);
    end
    mode = 2'd3;
    step(1);
    // Presses so far: keys 0,2,3,6,7 once each, key 4 three times.
    vec_count++;
    if (led !== 8'b1101_1101) begin
      err_count++;
      $display("FAIL toggle_back: got led=%b want 11011101", led);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    mode   = 2'd0;
    key    = 8'h20;
    step(2);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(1);
      vec_count++;
      if ({led, key_clean, press_pulse} !== 24'h000000) begin
        err_count++;
        $display("FAIL reset_mid_hold %0d: got led=%b clean=%b pulse=%b want all 0",
                 k, led, key_clean, press_pulse);
      end
    end
    reset  = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (press_pulse[5] === 1'b1) pulses++;
      vec_count++;
      if (key_clean[5] !== (k >= 6)) begin
        err_count++;
        $display("FAIL reset_mid_redebounce step %0d: got clean[5]=%b want %b", k, key_clean[5], k >= 6);
      end
    end
    vec_count++;
    if (pulses !== 1) begin
      err_count++;
      $display("FAIL reset_mid_pulses: got %0d want 1", pulses);
    end
    key = 8'h00;
    step(10);
  endtask

  // Simultaneous presses on keys 0, 1 and 7 pulse together at step 6.
  task automatic test_back_to_back();
    key = 8'h83;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      vec_count++;
      if (press_pulse !== ((k == 6) ? 8'h83 : 8'h00)) begin
        err_count++;
        $display("FAIL simultaneous step %0d: got pulse=%b want %b",
                 k, press_pulse, (k == 6) ? 8'h83 : 8'h00);
      end
    end
    key = 8'h00;
    step(10);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_bounce();
    test_and();
    test_or();
    test_toggle();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule : tb_key_logic_debounce
